clb_config_loader: RTL

- Bitstream-side writer for the slice configuration interface.
- Accepts a configuration stream over a valid/ready handshake and assembles one full slice configuration word.
- Presents the word on a parallel bus, then pulses cen for exactly one cclk cycle so the slice and its LUT/mux/register config stores capture it.
- Sits between the fabric config controller and one slicel instance.

---
 rtl/clb_config_loader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/clb_config_loader.sv
// clb_config_loader
//   Bitstream-side writer for one slicel configuration port. It takes
//   IN_WIDTH-bit beats over a valid/ready handshake, assembles them LSB-first
//   into a CFG_WIDTH-bit word, then pulses cen for one cclk cycle so the slice
//   LUT/mux/register config stores capture the word.
//   Word layout: {regs_config_in, config_use_cc, inter_lut_mux_config, luts_config_in}.
//   Optional build macro: CLB_CONFIG_PARITY_EN. When it is defined, every frame
//   carries one trailing parity beat, and a frame with bad parity is rejected
//   without a cen pulse.
module clb_config_loader #(
   parameter int CFG_WIDTH = 143,
   parameter int IN_WIDTH  = 8
) (
   input  logic                 cclk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 bs_valid,
   input  logic [IN_WIDTH-1:0]  bs_data,
   output logic                 bs_ready,
   output logic [CFG_WIDTH-1:0] config_out,
   output logic                 cen,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   // Number of data beats in one frame. The last beat may be only partly used.
   localparam int NUM_BEATS = (CFG_WIDTH + IN_WIDTH - 1) / IN_WIDTH;
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

`ifdef CLB_CONFIG_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CHECK = 3'd2,
      S_APPLY = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_APPLY = 3'd3,
      S_DONE  = 3'd4
   } state_t;
`endif

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CFG_WIDTH-1:0]   cfg_q;
   logic [CFG_WIDTH-1:0]   cfg_d;
   logic                   cen_q;
   logic                   done_q;
`ifdef CLB_CONFIG_PARITY_EN
   logic                   err_q;
   logic                   par_ok;
`endif

   // Merge the current beat into the word. Each config bit belongs to exactly
   // one beat, so a bit loads only when the counter selects that beat. Padding
   // bits of the final beat have no destination bit, so they are dropped.
   for (genvar b = 0; b < CFG_WIDTH; b++) begin : g_bit
      localparam logic [CNT_W-1:0] BEAT = CNT_W'(b / IN_WIDTH);
      assign cfg_d[b] = (cnt_q == BEAT) ? bs_data[b % IN_WIDTH] : cfg_q[b];
   end

`ifdef CLB_CONFIG_PARITY_EN
   // The parity beat must match the XOR of the assembled word only. Padding is
   // never stored, so it cannot affect the result.
   assign par_ok = (bs_data[0] == ^cfg_q);
`endif

   // Loader FSM and datapath. cen, done and err are driven directly from flops.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         cfg_q   <= '0;
         cen_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef CLB_CONFIG_PARITY_EN
         err_q   <= 1'b0;
`endif
      end else begin
         cen_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_LOAD;
                  cnt_q   <= '0;
                  cfg_q   <= '0;
               end
            end
            S_LOAD: begin
               // start is ignored in this state. A low bs_valid stalls the load.
               if (bs_valid) begin
                  cfg_q <= cfg_d;
                  if (cnt_q == LAST_BEAT) begin
`ifdef CLB_CONFIG_PARITY_EN
                     state_q <= S_CHECK;
`else
                     state_q <= S_APPLY;
                     cen_q   <= 1'b1;
`endif
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
`ifdef CLB_CONFIG_PARITY_EN
            S_CHECK: begin
               if (bs_valid) begin
                  if (par_ok) begin
                     state_q <= S_APPLY;
                     cen_q   <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_ERR: begin
               // Keep the rejected word visible for debug until the next frame.
               if (start) begin
                  state_q <= S_LOAD;
                  err_q   <= 1'b0;
                  cnt_q   <= '0;
                  cfg_q   <= '0;
               end
            end
`endif
            S_APPLY: begin
               // cen is high during this single cycle. The word is already stable.
               state_q <= S_DONE;
               done_q  <= 1'b1;
            end
            S_DONE: begin
               if (start) begin
                  state_q <= S_LOAD;
                  done_q  <= 1'b0;
                  cnt_q   <= '0;
                  cfg_q   <= '0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               cfg_q   <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Handshake and status outputs are decoded from the registered state.
`ifdef CLB_CONFIG_PARITY_EN
   assign bs_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
   assign busy     = (state_q == S_LOAD) || (state_q == S_CHECK) || (state_q == S_APPLY);
   assign err      = err_q;
`else
   assign bs_ready = (state_q == S_LOAD);
   assign busy     = (state_q == S_LOAD) || (state_q == S_APPLY);
   assign err      = 1'b0;
`endif

   assign config_out = cfg_q;
   assign cen        = cen_q;
   assign done       = done_q;

endmodule
